// File: rtl/mem_handshake_ctrl.sv
// Word-addressed memory answering CPU requests over a four-phase enable/MFC handshake,
// with programmable access latency and an optional write-protected low region.
module mem_handshake_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2,
    parameter int ROM_LIMIT  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  mem_enable,
    input  logic                  mem_rw,
    output logic                  mfc,
    output logic                  err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0]          LAT_LOAD = 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] PROT_LIM = (ADDR_WIDTH + 1)'(ROM_LIMIT);

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rw_q;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic protected_addr;
    logic complete;
    logic mem_we;

    assign protected_addr = ({1'b0, addr_q} < PROT_LIM);
    assign complete       = (state == WAIT) && mem_enable && (cnt == 4'd0);
    // Reset on the completing edge must still suppress the store.
    assign mem_we         = complete && rw_q && !protected_addr && !reset;

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[addr_q] <= data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mfc       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            read_data <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rw_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_enable) begin
                        addr_q <= address;
                        data_q <= write_data;
                        rw_q   <= mem_rw;
                        cnt    <= LAT_LOAD;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_enable) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!rw_q)
                            read_data <= mem[addr_q];
                        else if (protected_addr)
                            err <= 1'b1;
                        mfc   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Enable held high keeps us here; a new access needs a pass through IDLE.
                    if (!mem_enable) begin
                        mfc   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Scoreboard bench: three instances (latency 2 with protected low region, latency 1, latency 5)
// driven by directed accesses; a monitor checks each MFC rise against queued expectations.
module tb_mem_handshake_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address    [3];
    logic [15:0] write_data [3];
    logic [15:0] read_data  [3];
    logic        mem_enable [3];
    logic        mem_rw     [3];
    logic        mfc        [3];
    logic        err        [3];
    logic        busy       [3];

    always #5 clock = ~clock;

    mem_handshake_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LATENCY(2), .ROM_LIMIT(8)) dut0 (
        .clock(clock), .reset(reset), .address(address[0]), .write_data(write_data[0]),
        .read_data(read_data[0]), .mem_enable(mem_enable[0]), .mem_rw(mem_rw[0]),
        .mfc(mfc[0]), .err(err[0]), .busy(busy[0]));

    mem_handshake_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LATENCY(1), .ROM_LIMIT(0)) dut1 (
        .clock(clock), .reset(reset), .address(address[1]), .write_data(write_data[1]),
        .read_data(read_data[1]), .mem_enable(mem_enable[1]), .mem_rw(mem_rw[1]),
        .mfc(mfc[1]), .err(err[1]), .busy(busy[1]));

    mem_handshake_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LATENCY(5), .ROM_LIMIT(0)) dut2 (
        .clock(clock), .reset(reset), .address(address[2]), .write_data(write_data[2]),
        .read_data(read_data[2]), .mem_enable(mem_enable[2]), .mem_rw(mem_rw[2]),
        .mfc(mfc[2]), .err(err[2]), .busy(busy[2]));

    typedef struct {
        int          inst;
        logic [15:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd_model [3];
    logic        mfc_d    [3] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (mfc[i] === 1'b1 && mfc_d[i] === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mfc inst %0d: got mfc=1 expected no response", i);
                end else begin
                    e = sb.pop_front();
                    check("sb_inst", i, e.inst);
                    check("sb_read_data", read_data[i], e.rd);
                    check("sb_err", err[i], e.err);
                end
            end
            mfc_d[i] <= mfc[i];
        end
    end

    task automatic access(input int i, input logic [15:0] a, input logic rw, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input logic exp_err, input int lat, input int hold);
        int k;
        @(negedge clock);
        address[i]    = a;
        write_data[i] = wd;
        mem_rw[i]     = rw;
        mem_enable[i] = 1'b1;
        sb.push_back('{i, exp_rd, exp_err});
        @(posedge clock); #1;
        // Latched copies must be used from here on.
        address[i]    = a ^ 16'h00FF;
        write_data[i] = ~wd;
        mem_rw[i]     = ~rw;
        k = 0;
        while (k < 40) begin
            @(posedge clock); #1;
            k++;
            if (mfc[i] === 1'b1) break;
        end
        check("mfc_latency", k, lat);
        check("busy_in_done", busy[i], 1);
        for (int h = 0; h < hold; h++) begin
            address[i] = a + 16'(h + 1);
            @(posedge clock); #1;
            check("mfc_held", mfc[i], 1);
        end
        @(negedge clock);
        mem_enable[i] = 1'b0;
        @(posedge clock); #1;
        check("mfc_drop", mfc[i], 0);
        check("err_drop", err[i], 0);
        check("busy_idle", busy[i], 0);
        check("read_data_hold", read_data[i], exp_rd);
    endtask

    task automatic wr(input int i, input logic [15:0] a, input logic [15:0] d, input int lat,
                      input logic exp_err, input int hold);
        access(i, a, 1'b1, d, rd_model[i], exp_err, lat, hold);
    endtask

    task automatic rd(input int i, input logic [15:0] a, input logic [15:0] exp, input int lat);
        rd_model[i] = exp;
        access(i, a, 1'b0, 16'h0000, exp, 1'b0, lat, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address[i] = '0; write_data[i] = '0; mem_enable[i] = 1'b0; mem_rw[i] = 1'b0;
            rd_model[i] = '0;
        end
        dut0.mem[3] = 16'h5A5A;
        dut0.mem[7] = 16'h7777;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mfc", mfc[i], 0);
            check("rst_err", err[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_read_data", read_data[i], 0);
        end
        @(negedge clock) reset = 1'b0;

        // basic write then read
        wr(0, 16'h0010, 16'h1234, 2, 1'b0, 0);
        rd(0, 16'h0010, 16'h1234, 2);

        // aborted write leaves the old contents
        wr(0, 16'h0020, 16'h1111, 2, 1'b0, 0);
        @(negedge clock);
        address[0] = 16'h0020; write_data[0] = 16'hBEEF; mem_rw[0] = 1'b1; mem_enable[0] = 1'b1;
        @(posedge clock);
        @(negedge clock) mem_enable[0] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (mfc[0] === 1'b1) seen = 1'b1;
        end
        check("abort_no_mfc", seen, 0);
        check("abort_idle", busy[0], 0);
        rd(0, 16'h0020, 16'h1111, 2);

        // protection boundary
        wr(0, 16'h0003, 16'hFFFF, 2, 1'b1, 0);
        rd(0, 16'h0003, 16'h5A5A, 2);
        wr(0, 16'h0007, 16'h0000, 2, 1'b1, 0);
        rd(0, 16'h0007, 16'h7777, 2);
        wr(0, 16'h0008, 16'h0808, 2, 1'b0, 0);
        rd(0, 16'h0008, 16'h0808, 2);

        // enable held after MFC with address wandering
        wr(0, 16'h0040, 16'hA5A5, 2, 1'b0, 5);
        rd(0, 16'h0040, 16'hA5A5, 2);

        // reset in WAIT aborts the store
        wr(0, 16'h0030, 16'h3333, 2, 1'b0, 0);
        @(negedge clock);
        address[0] = 16'h0030; write_data[0] = 16'hDEAD; mem_rw[0] = 1'b1; mem_enable[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        mem_enable[0] = 1'b0;
        @(posedge clock); #1;
        check("wait_rst_mfc", mfc[0], 0);
        check("wait_rst_busy", busy[0], 0);
        check("wait_rst_read_data", read_data[0], 0);
        for (int i = 0; i < 3; i++) rd_model[i] = '0;
        @(negedge clock) reset = 1'b0;
        rd(0, 16'h0030, 16'h3333, 2);

        // latency sweep
        wr(1, 16'h0100, 16'hCAFE, 1, 1'b0, 0);
        rd(1, 16'h0100, 16'hCAFE, 1);
        wr(1, 16'h0000, 16'h0101, 1, 1'b0, 0);
        rd(1, 16'h0000, 16'h0101, 1);
        wr(2, 16'h0200, 16'hF00D, 5, 1'b0, 0);
        rd(2, 16'h0200, 16'hF00D, 5);
        wr(2, 16'hFFFF, 16'h8001, 5, 1'b0, 2);
        rd(2, 16'hFFFF, 16'h8001, 5);

        repeat (3) @(posedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
